// File: rtl/pcie_rx_pkg.sv
// Shared PCIe receive-side codes: byte classes, packet kinds and assembler states.
// The byte classifier and the packet assembler both import this package.
package pcie_rx_pkg;

   localparam logic [5:0] TYPE_DATA      = 6'b100000;
   localparam logic [5:0] TYPE_TLPSTART  = 6'b010000;
   localparam logic [5:0] TYPE_TLPEND    = 6'b001000;
   localparam logic [5:0] TYPE_DLLPEND   = 6'b000100;
   localparam logic [5:0] TYPE_DLLPSTART = 6'b000010;
   localparam logic [5:0] TYPE_TLPEDB    = 6'b000001;
   localparam logic [5:0] TYPE_NONE      = 6'b000000;

   localparam logic [1:0] KIND_NONE = 2'b00;
   localparam logic [1:0] KIND_TLP  = 2'b01;
   localparam logic [1:0] KIND_DLLP = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_COLLECT = 2'b01,
      ST_DRAIN   = 2'b10
   } asm_state_e;

   function automatic logic is_start_type(input logic [5:0] t);
      return (t == TYPE_TLPSTART) || (t == TYPE_DLLPSTART);
   endfunction

   function automatic logic is_end_type(input logic [5:0] t);
      return (t == TYPE_TLPEND) || (t == TYPE_DLLPEND);
   endfunction

endpackage

// File: rtl/rx_byte_buf.sv
// Payload byte store: synchronous write, asynchronous read, no reset on contents.
module rx_byte_buf #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_packet_assembler.sv
// Collects the payload bytes of one TLP/DLLP between start and end markers,
// then drains them through a valid/ready byte stream.
module rx_packet_assembler
   import pcie_rx_pkg::*;
#(
   parameter int MAX_BYTES = 32,
   parameter int LEN_W     = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid,
   input  logic [5:0] type_in,
   input  logic [1:0] kind_in,
   output logic [1:0] kind_state,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic [1:0] out_kind,
   output logic       edb_drop,
   output logic       err_pulse
);

   localparam int AW = $clog2(MAX_BYTES);

   asm_state_e       state_q;
   logic [LEN_W-1:0] count_q;
   logic [LEN_W-1:0] rd_ptr_q;
   logic [LEN_W-1:0] len_q;
   logic [1:0]       pkt_kind_q;
   logic [1:0]       kind_q;
   logic             edb_q;
   logic             err_q;

   logic             v_start, v_data, v_end, v_edb;
   logic             buf_full;
   logic             buf_we;
   logic [7:0]       rd_data;
   logic             draining;
   logic             at_last;

   assign v_start  = valid && is_start_type(type_in);
   assign v_data   = valid && (type_in == TYPE_DATA);
   assign v_end    = valid && is_end_type(type_in);
   assign v_edb    = valid && (type_in == TYPE_TLPEDB);
   assign buf_full = (count_q == LEN_W'(MAX_BYTES));
   assign buf_we   = (state_q == ST_COLLECT) && v_data && !buf_full;

   rx_byte_buf #(
      .DEPTH (MAX_BYTES),
      .AW    (AW)
   ) u_buf (
      .clk_i   (clk),
      .we_i    (buf_we),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i (data_in),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rd_data)
   );

   // Output stream is a pure decode of registered state, so it cannot move during a stall.
   assign draining   = (state_q == ST_DRAIN);
   assign at_last    = (rd_ptr_q == (len_q - LEN_W'(1)));
   assign out_valid  = draining;
   assign out_data   = draining ? rd_data : 8'h00;
   assign out_last   = draining && at_last;
   assign out_kind   = draining ? pkt_kind_q : KIND_NONE;
   assign kind_state = kind_q;
   assign edb_drop   = edb_q;
   assign err_pulse  = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         len_q      <= '0;
         pkt_kind_q <= KIND_NONE;
         kind_q     <= KIND_NONE;
         edb_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         edb_q <= 1'b0;
         err_q <= 1'b0;
         if (valid) kind_q <= kind_in;
         case (state_q)
            ST_IDLE: begin
               if (v_start) begin
                  state_q    <= ST_COLLECT;
                  pkt_kind_q <= kind_in;
                  count_q    <= '0;
               end
            end
            ST_COLLECT: begin
               if (v_start) begin
                  err_q      <= 1'b1;
                  pkt_kind_q <= kind_in;
                  count_q    <= '0;
               end else if (v_data) begin
                  if (buf_full) begin
                     err_q   <= 1'b1;
                     state_q <= ST_IDLE;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + LEN_W'(1);
                  end
               end else if (v_end) begin
                  if (count_q != '0) begin
                     state_q  <= ST_DRAIN;
                     len_q    <= count_q;
                     rd_ptr_q <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else if (v_edb) begin
                  edb_q   <= 1'b1;
                  state_q <= ST_IDLE;
                  count_q <= '0;
               end
            end
            ST_DRAIN: begin
               // A start byte here is an overrun: flag it and let the drain finish untouched.
               if (v_start) err_q <= 1'b1;
               if (out_ready) begin
                  if (at_last) state_q  <= ST_IDLE;
                  else         rd_ptr_q <= rd_ptr_q + LEN_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_packet_assembler.sv
// Bench for rx_packet_assembler: packet-level queue model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_rx_packet_assembler;

   localparam int MAXB = 32;
   localparam logic [5:0] T_DATA = 6'b100000;
   localparam logic [5:0] T_STP  = 6'b010000;
   localparam logic [5:0] T_TEND = 6'b001000;
   localparam logic [5:0] T_DEND = 6'b000100;
   localparam logic [5:0] T_SDP  = 6'b000010;
   localparam logic [5:0] T_EDB  = 6'b000001;
   localparam logic [5:0] T_NONE = 6'b000000;
   localparam logic [1:0] K_TLP  = 2'b01;
   localparam logic [1:0] K_DLLP = 2'b10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [5:0] type_in = T_NONE;
   logic [1:0] kind_in = 2'b00;
   logic [1:0] kind_state, out_kind;
   logic       out_valid, out_last, edb_drop, err_pulse;
   logic [7:0] out_data;

   rx_packet_assembler dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .valid      (valid),
      .type_in    (type_in),
      .kind_in    (kind_in),
      .kind_state (kind_state),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_kind   (out_kind),
      .edb_drop   (edb_drop),
      .err_pulse  (err_pulse)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Packet-level model: bytes of the packet being gathered, bytes still owed to the sink.
   bit         collecting = 1'b0;
   logic [7:0] cur[$];
   logic [1:0] cur_k = 2'b00;
   logic [7:0] outq[$];
   logic [1:0] out_k = 2'b00;
   logic [1:0] exp_ks = 2'b00;
   bit         exp_edb = 1'b0;
   bit         exp_err = 1'b0;

   logic [7:0] got[$];
   logic [7:0] want[$];
   int n_err = 0, n_edb = 0, n_last = 0, first_v = -1, step_n = 0, e = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (step %0d)", nm, act, exp, step_n);
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", int'(out_valid), int'(outq.size() > 0));
      if (outq.size() > 0) begin
         chk("out_data", int'(out_data), int'(outq[0]));
         chk("out_last", int'(out_last), int'(outq.size() == 1));
         chk("out_kind", int'(out_kind), int'(out_k));
      end else begin
         chk("out_last_idle", int'(out_last), 0);
      end
      chk("kind_state", int'(kind_state), int'(exp_ks));
      chk("edb_drop", int'(edb_drop), int'(exp_edb));
      chk("err_pulse", int'(err_pulse), int'(exp_err));
      if (out_valid && first_v < 0) first_v = step_n;
      if (err_pulse) n_err++;
      if (edb_drop) n_edb++;
   endtask

   task automatic model_step(input logic v, input logic [5:0] t, input logic [1:0] k,
                             input logic [7:0] d, input logic rdy);
      exp_edb = 1'b0;
      exp_err = 1'b0;
      if (v) exp_ks = k;
      if (outq.size() > 0) begin
         if (rdy) void'(outq.pop_front());
         if (v && (t == T_STP || t == T_SDP)) exp_err = 1'b1;
      end else if (!collecting) begin
         if (v && (t == T_STP || t == T_SDP)) begin
            collecting = 1'b1;
            cur.delete();
            cur_k = k;
         end
      end else if (v) begin
         if (t == T_DATA) begin
            if (cur.size() == MAXB) begin
               exp_err = 1'b1;
               collecting = 1'b0;
               cur.delete();
            end else begin
               cur.push_back(d);
            end
         end else if (t == T_STP || t == T_SDP) begin
            exp_err = 1'b1;
            cur.delete();
            cur_k = k;
         end else if (t == T_TEND || t == T_DEND) begin
            collecting = 1'b0;
            if (cur.size() > 0) begin
               outq = cur;
               out_k = cur_k;
            end
            cur.delete();
         end else if (t == T_EDB) begin
            exp_edb = 1'b1;
            collecting = 1'b0;
            cur.delete();
         end
      end
   endtask

   task automatic cyc(input logic v, input logic [5:0] t, input logic [1:0] k,
                      input logic [7:0] d, input logic rdy);
      @(negedge clk);
      step_n++;
      check_outputs();
      valid = v; type_in = t; kind_in = k; data_in = d; out_ready = rdy;
      if (out_valid && rdy) begin
         got.push_back(out_data);
         if (out_last) n_last++;
      end
      model_step(v, t, k, d, rdy);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, T_NONE, 2'b00, 8'h00, rdy);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      step_n++;
      check_outputs();
      valid = 1'b0; type_in = T_NONE; kind_in = 2'b00; out_ready = 1'b0;
      reset = 1'b1;
      collecting = 1'b0; cur.delete(); outq.delete();
      exp_ks = 2'b00; exp_edb = 1'b0; exp_err = 1'b0;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_kind", int'(out_kind), 0);
      chk("rst_kind_state", int'(kind_state), 0);
      chk("rst_edb_drop", int'(edb_drop), 0);
      chk("rst_err_pulse", int'(err_pulse), 0);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   task automatic clear_obs();
      got.delete(); want.delete();
      n_err = 0; n_edb = 0; n_last = 0; first_v = -1;
   endtask

   task automatic chk_got(input string nm);
      chk({nm, "_count"}, got.size(), want.size());
      for (int i = 0; i < want.size() && i < got.size(); i++)
         chk({nm, "_byte"}, int'(got[i]), int'(want[i]));
   endtask

   task automatic rand_phase(input int n, input int sw, input int ew);
      for (int i = 0; i < n; i++) begin
         int r;
         logic v;
         logic [5:0] t;
         r = int'($urandom_range(0, 99));
         v = 1'b1;
         if (r < 10) begin v = 1'b0; t = T_DATA; end
         else if (r < 10 + sw)            t = T_STP;
         else if (r < 10 + 2*sw)          t = T_SDP;
         else if (r < 10 + 2*sw + ew)     t = T_TEND;
         else if (r < 10 + 2*sw + 2*ew)   t = T_DEND;
         else if (r < 11 + 2*sw + 2*ew)   t = T_EDB;
         else if (r < 13 + 2*sw + 2*ew)   t = T_NONE;
         else                             t = T_DATA;
         cyc(v, t, 2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 3) != 0));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      apply_reset();

      // TLP, sink always ready
      clear_obs();
      cyc(1, T_STP, K_TLP, 8'h00, 1);
      cyc(1, T_DATA, K_TLP, 8'h11, 1);
      cyc(1, T_DATA, K_TLP, 8'h22, 1);
      cyc(1, T_DATA, K_TLP, 8'h33, 1);
      cyc(1, T_TEND, K_TLP, 8'h00, 1);
      e = step_n;
      idle(6, 1);
      want.push_back(8'h11); want.push_back(8'h22); want.push_back(8'h33);
      chk_got("tlp");
      chk("tlp_last_count", n_last, 1);
      chk("tlp_latency", first_v - e, 1);
      chk("tlp_err_count", n_err, 0);

      // DLLP with toggling backpressure
      clear_obs();
      cyc(1, T_SDP, K_DLLP, 8'h00, 0);
      for (int i = 0; i < 6; i++) cyc(1, T_DATA, K_DLLP, 8'hA0 + 8'(i), 0);
      cyc(1, T_DEND, K_DLLP, 8'h00, 0);
      e = step_n;
      for (int i = 0; i < 16; i++) cyc(0, T_NONE, 2'b00, 8'h00, (i % 2) == 0);
      for (int i = 0; i < 6; i++) want.push_back(8'hA0 + 8'(i));
      chk_got("dllp");
      chk("dllp_last_count", n_last, 1);
      chk("dllp_latency", first_v - e, 1);

      // EDB discard
      clear_obs();
      cyc(1, T_STP, K_TLP, 8'h00, 1);
      cyc(1, T_DATA, K_TLP, 8'hAA, 1);
      cyc(1, T_DATA, K_TLP, 8'hBB, 1);
      cyc(1, T_EDB, K_TLP, 8'h00, 1);
      idle(4, 1);
      chk("edb_count", n_edb, 1);
      chk("edb_no_output", first_v, -1);
      chk("edb_err_count", n_err, 0);

      // Overflow, then a clean single-byte packet
      clear_obs();
      cyc(1, T_STP, K_TLP, 8'h00, 1);
      for (int i = 0; i < 33; i++) cyc(1, T_DATA, K_TLP, 8'(i), 1);
      idle(3, 1);
      chk("ovf_err_count", n_err, 1);
      chk("ovf_no_output", first_v, -1);
      clear_obs();
      cyc(1, T_STP, K_TLP, 8'h00, 1);
      cyc(1, T_DATA, K_TLP, 8'h55, 1);
      cyc(1, T_TEND, K_TLP, 8'h00, 1);
      idle(4, 1);
      want.push_back(8'h55);
      chk_got("after_ovf");
      chk("after_ovf_last", n_last, 1);

      // Restart inside a packet
      clear_obs();
      cyc(1, T_STP, K_TLP, 8'h00, 1);
      cyc(1, T_DATA, K_TLP, 8'h01, 1);
      cyc(1, T_STP, K_TLP, 8'h00, 1);
      cyc(1, T_DATA, K_TLP, 8'h02, 1);
      cyc(1, T_TEND, K_TLP, 8'h00, 1);
      idle(4, 1);
      want.push_back(8'h02);
      chk_got("restart");
      chk("restart_err_count", n_err, 1);

      // Overrun: DLLP start while a stalled drain is pending
      clear_obs();
      cyc(1, T_STP, K_TLP, 8'h00, 0);
      cyc(1, T_DATA, K_TLP, 8'hC1, 0);
      cyc(1, T_DATA, K_TLP, 8'hC2, 0);
      cyc(1, T_DATA, K_TLP, 8'hC3, 0);
      cyc(1, T_TEND, K_TLP, 8'h00, 0);
      cyc(1, T_SDP, K_DLLP, 8'h00, 0);
      cyc(1, T_DATA, K_DLLP, 8'h77, 0);
      idle(3, 0);
      cyc(1, T_DEND, K_DLLP, 8'h00, 0);
      idle(6, 1);
      want.push_back(8'hC1); want.push_back(8'hC2); want.push_back(8'hC3);
      chk_got("overrun");
      chk("overrun_err_count", n_err, 1);

      // Reset in the middle of collection
      clear_obs();
      cyc(1, T_STP, K_TLP, 8'h00, 1);
      cyc(1, T_DATA, K_TLP, 8'h10, 1);
      apply_reset();
      cyc(1, T_TEND, K_TLP, 8'h00, 1);
      idle(4, 1);
      chk("rst_mid_no_output", first_v, -1);
      chk("rst_mid_err_count", n_err, 0);

      // Randomized traffic: short packets, then long packets that can overflow
      rand_phase(2500, 4, 5);
      rand_phase(2500, 1, 1);
      apply_reset();
      rand_phase(1000, 3, 3);
      idle(40, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rx_packet_assembler.md
RX_PACKET_ASSEMBLER -- requirements
Module: rx_packet_assembler

Interface
REQ-001 Parameter MAX_BYTES, default 32, payload buffer depth in bytes, power of two.
REQ-002 Parameter LEN_W, default 6, length/pointer width; SHALL be at least log2(MAX_BYTES)+1.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 data_in  in  8  received byte, aligned with type_in.
REQ-007 valid  in  1  byte-strobe qualifying data_in/type_in.
REQ-008 type_in  in  6  one-hot byte class: 100000 data, 010000 tlpstart, 001000 tlpend, 000100 dllpend, 000010 dllpstart, 000001 tlpedb, 000000 none.
REQ-009 kind_in  in  2  packet kind from classifier (01 TLP, 10 DLLP, 00 none).
REQ-010 kind_state  out  2  registered kind, fed back as the classifier's kind input.
REQ-011 out_valid  out  1  output byte available.
REQ-012 out_ready  in  1  sink accepts output byte.
REQ-013 out_data  out  8  payload byte.
REQ-014 out_last  out  1  final byte of packet.
REQ-015 out_kind  out  2  kind of packet being drained.
REQ-016 edb_drop  out  1  one-cycle pulse: packet discarded on EDB.
REQ-017 err_pulse  out  1  one-cycle pulse: overflow, restart or overrun.

Function
REQ-018 kind_state SHALL load kind_in on every clk edge with valid=1 and hold otherwise, in all FSM states.
REQ-019 FSM states SHALL be IDLE, COLLECT, DRAIN.
REQ-020 IDLE: valid with tlpstart or dllpstart -> COLLECT, latch pkt_kind=kind_in, count=0; the start byte is not stored; all other classes ignored.
REQ-021 COLLECT, data class: write data_in to buf[count], count+1.
REQ-022 COLLECT, data class with count==MAX_BYTES: discard packet, err_pulse, -> IDLE.
REQ-023 COLLECT, tlpend or dllpend: count>0 -> DRAIN with len=count, rd_ptr=0; count==0 -> IDLE silently.
REQ-024 COLLECT, tlpedb: discard, edb_drop pulse, -> IDLE.
REQ-025 COLLECT, tlpstart or dllpstart: discard current packet, err_pulse, restart collection (count=0, new pkt_kind); stay in COLLECT.
REQ-026 COLLECT, none class or valid=0: no change.
REQ-027 DRAIN: out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==len-1), out_kind=pkt_kind.
REQ-028 DRAIN: out_valid&out_ready advances rd_ptr; transfer with out_last -> IDLE next cycle.
REQ-029 out_data/out_last/out_kind SHALL stay stable while out_valid=1 and out_ready=0.
REQ-030 DRAIN: valid start byte -> err_pulse (overrun), byte and following packet ignored; DRAIN unaffected.
REQ-031 First out_valid SHALL assert the cycle after the end byte is sampled (1-cycle latency).
REQ-032 Outside DRAIN, out_valid=0, out_last=0; edb_drop/err_pulse are registered, high exactly one cycle.

Reset
REQ-033 reset SHALL force IDLE, count=0, rd_ptr=0, len=0, kind_state=00, pkt_kind=00, out_valid=0, out_last=0, out_data=0, out_kind=00, edb_drop=0, err_pulse=0.
REQ-034 reset mid-COLLECT or mid-DRAIN SHALL abandon the packet with no pulse; buffer contents need not be cleared.

Structure
REQ-035 Type one-hot codes, kind codes (TLP/DLLP/none) and FSM state encoding SHALL live in shared package pcie_rx_pkg, also used by the classifier.
REQ-036 Payload storage SHALL be one sub-module rx_byte_buf (MAX_BYTES x 8, sync write, async read); FSM and counters stay in rx_packet_assembler.

Verification
REQ-037 TLP: STP, data 0x11,0x22,0x33, END with out_ready=1 -> out bytes 11,22,33, out_last on 33, out_kind=01, out_valid first the cycle after END.
REQ-038 DLLP with backpressure: SDP, 6 bytes, END, out_ready toggling 1/0 -> 6 bytes in order, out_kind=10, outputs stable during stalls.
REQ-039 EDB: STP, 0xAA,0xBB, EDB -> edb_drop one cycle, out_valid never asserts, FSM in IDLE.
REQ-040 Overflow: STP then 33 data bytes (MAX_BYTES=32) -> err_pulse on 33rd, no output; next STP, 0x55, END -> single byte 55.
REQ-041 Overrun and restart: STP,0x01,STP,0x02,END -> err_pulse, output only 02; SDP arriving during DRAIN with out_ready=0 -> err_pulse, drain completes unchanged.
REQ-042 Reset after STP, 0x10 -> all outputs at reset values, kind_state=00; subsequent END produces no output.
